// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: CPU and loader request ports plus the external memory port.
// The arbiter connects through the slave modport; requesters and the memory model use master.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        ld_req;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_ack;
  logic [7:0]  ld_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_read;
  logic        mem_write;

  logic        busy;
  logic        grant_id;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output busy, grant_id
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / program loader) arbiter for a single 8-bit memory port,
// with a fixed MEM_LAT-cycle strobe window and a one-cycle ack pulse per access.
module mem_arbiter #(
  parameter int unsigned MEM_LAT  = 2,
  parameter bit          CPU_PRIO = 1'b0
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       we_q;
  logic       last_grant;
  logic       pick_ld;

  // On a tie, round-robin favours whoever did not own the port last time.
  always_comb begin
    pick_ld = bus.ld_req;
    if (bus.cpu_req && bus.ld_req)
      pick_ld = CPU_PRIO ? 1'b0 : ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      last_grant    <= 1'b1;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ld_ack    <= 1'b0;
      bus.ld_rdata  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.busy      <= 1'b0;
      bus.grant_id  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.ld_req) begin
            bus.grant_id  <= pick_ld;
            bus.mem_addr  <= pick_ld ? bus.ld_addr  : bus.cpu_addr;
            bus.mem_wdata <= pick_ld ? bus.ld_wdata : bus.cpu_wdata;
            we_q          <= pick_ld ? bus.ld_we    : bus.cpu_we;
            bus.mem_read  <= pick_ld ? ~bus.ld_we   : ~bus.cpu_we;
            bus.mem_write <= pick_ld ? bus.ld_we    : bus.cpu_we;
            bus.busy      <= 1'b1;
            cnt           <= '0;
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == LAST) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (!we_q) begin
              if (bus.grant_id) bus.ld_rdata  <= bus.mem_rdata;
              else              bus.cpu_rdata <= bus.mem_rdata;
            end
            if (bus.grant_id) bus.ld_ack  <= 1'b1;
            else              bus.cpu_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          bus.cpu_ack <= 1'b0;
          bus.ld_ack  <= 1'b0;
          last_grant  <= bus.grant_id;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          bus.cpu_ack   <= 1'b0;
          bus.ld_ack    <= 1'b0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin (MEM_LAT=2) and a fixed-priority (MEM_LAT=3) instance
// share stimulus; each is compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic        c_req, c_we;
  logic [15:0] c_addr;
  logic [7:0]  c_wd;
  logic        l_req, l_we;
  logic [15:0] l_addr;
  logic [7:0]  l_wd;

  int total;
  int bad;
  int cyc;

  logic [7:0] mem_dev0 [256];
  logic [7:0] mem_dev1 [256];
  logic [7:0] ref_mem  [2][256];

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  assign bus0.cpu_req   = c_req;
  assign bus0.cpu_we    = c_we;
  assign bus0.cpu_addr  = c_addr;
  assign bus0.cpu_wdata = c_wd;
  assign bus0.ld_req    = l_req;
  assign bus0.ld_we     = l_we;
  assign bus0.ld_addr   = l_addr;
  assign bus0.ld_wdata  = l_wd;
  assign bus0.mem_rdata = mem_dev0[bus0.mem_addr[7:0]];

  assign bus1.cpu_req   = c_req;
  assign bus1.cpu_we    = c_we;
  assign bus1.cpu_addr  = c_addr;
  assign bus1.cpu_wdata = c_wd;
  assign bus1.ld_req    = l_req;
  assign bus1.ld_we     = l_we;
  assign bus1.ld_addr   = l_addr;
  assign bus1.ld_wdata  = l_wd;
  assign bus1.mem_rdata = mem_dev1[bus1.mem_addr[7:0]];

  mem_arbiter #(.MEM_LAT(2), .CPU_PRIO(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(bus0));
  mem_arbiter #(.MEM_LAT(3), .CPU_PRIO(1'b1)) u_fp (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: one in-flight transaction per instance, timed from its grant edge.
  bit          act   [2];
  int          g     [2];
  bit          own   [2];
  bit          mwe   [2];
  logic [15:0] maddr [2];
  logic [7:0]  mwd   [2];
  logic [7:0]  crd   [2];
  logic [7:0]  lrd   [2];
  bit          lastg [2];
  bit          gid   [2];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic bit prio(input int d);
    return d == 1;
  endfunction

  task automatic model_edge(input int d);
    bit win;
    if (rst) begin
      act[d] = 0; lastg[d] = 1; gid[d] = 0;
      maddr[d] = '0; mwd[d] = '0; crd[d] = '0; lrd[d] = '0;
    end else if (!act[d]) begin
      if (c_req || l_req) begin
        if (c_req && l_req) win = prio(d) ? 1'b0 : !lastg[d];
        else                win = l_req;
        act[d] = 1; g[d] = cyc; own[d] = win; gid[d] = win;
        mwe[d]   = win ? l_we   : c_we;
        maddr[d] = win ? l_addr : c_addr;
        mwd[d]   = win ? l_wd   : c_wd;
      end
    end else if (cyc == g[d] + lat(d)) begin
      if (!mwe[d]) begin
        if (own[d]) lrd[d] = ref_mem[d][maddr[d][7:0]];
        else        crd[d] = ref_mem[d][maddr[d][7:0]];
      end
    end else if (cyc == g[d] + lat(d) + 1) begin
      act[d] = 0; lastg[d] = own[d];
      if (mwe[d]) ref_mem[d][maddr[d][7:0]] = mwd[d];
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic rd, input logic wr, input logic [15:0] ad,
                           input logic [7:0] wd, input logic ca, input logic [7:0] cr,
                           input logic la, input logic [7:0] lr, input logic bz, input logic gi);
    int k;
    bit strobe, ack;
    k = cyc - g[d];
    strobe = act[d] && (k < lat(d));
    ack    = act[d] && (k == lat(d));
    chk("mem_read",  d, 16'(rd), 16'(strobe && !mwe[d]));
    chk("mem_write", d, 16'(wr), 16'(strobe && mwe[d]));
    chk("mem_addr",  d, ad, maddr[d]);
    chk("mem_wdata", d, 16'(wd), 16'(mwd[d]));
    chk("cpu_ack",   d, 16'(ca), 16'(ack && !own[d]));
    chk("ld_ack",    d, 16'(la), 16'(ack && own[d]));
    chk("cpu_rdata", d, 16'(cr), 16'(crd[d]));
    chk("ld_rdata",  d, 16'(lr), 16'(lrd[d]));
    chk("busy",      d, 16'(bz), 16'(act[d]));
    chk("grant_id",  d, 16'(gi), 16'(gid[d]));
  endtask

  task automatic step();
    logic       w0, w1;
    logic [7:0] a0, a1, d0, d1;
    w0 = bus0.mem_write; a0 = bus0.mem_addr[7:0]; d0 = bus0.mem_wdata;
    w1 = bus1.mem_write; a1 = bus1.mem_addr[7:0]; d1 = bus1.mem_wdata;
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    if (w0) mem_dev0[a0] = d0;
    if (w1) mem_dev1[a1] = d1;
    check_dut(0, bus0.mem_read, bus0.mem_write, bus0.mem_addr, bus0.mem_wdata, bus0.cpu_ack,
              bus0.cpu_rdata, bus0.ld_ack, bus0.ld_rdata, bus0.busy, bus0.grant_id);
    check_dut(1, bus1.mem_read, bus1.mem_write, bus1.mem_addr, bus1.mem_wdata, bus1.cpu_ack,
              bus1.cpu_rdata, bus1.ld_ack, bus1.ld_rdata, bus1.busy, bus1.grant_id);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wd = '0;
    for (int i = 0; i < 256; i++) begin
      mem_dev0[i]   = 8'(i * 7 + 3);
      mem_dev1[i]   = 8'(i * 7 + 3);
      ref_mem[0][i] = 8'(i * 7 + 3);
      ref_mem[1][i] = 8'(i * 7 + 3);
    end
    mem_dev0[16] = 8'h5A; mem_dev1[16] = 8'h5A;
    ref_mem[0][16] = 8'h5A; ref_mem[1][16] = 8'h5A;
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; g[d] = 0; own[d] = 0; mwe[d] = 0; lastg[d] = 1; gid[d] = 0;
      maddr[d] = '0; mwd[d] = '0; crd[d] = '0; lrd[d] = '0;
    end
    @(negedge clk);
    steps(2);
    rst = 1'b0;
    steps(1);

    // single CPU read of 0x0010 returning 0x5A
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    step();
    c_req = 1'b0;
    steps(6);

    // loader write of 0xC4 to 0x0003
    l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0003; l_wd = 8'hC4;
    step();
    l_req = 1'b0;
    steps(6);

    // fresh reset, then both requesting continuously
    rst = 1'b1; step(); rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0021;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0042;
    steps(16);
    // CPU drops out: loader must be served next on the fixed-priority instance too
    c_req = 1'b0;
    steps(8);
    l_req = 1'b0;
    steps(6);

    // CPU drops req one cycle into ACCESS
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0077;
    steps(2);
    c_req = 1'b0;
    steps(6);

    // reset during the second ACCESS cycle of a write, then a tie
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0055; c_wd = 8'h99;
    steps(2);
    rst = 1'b1; step(); rst = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0056; l_wd = 8'h3C;
    steps(10);
    c_req = 1'b0; l_req = 1'b0;
    steps(6);

    // randomized traffic; fields change only while the requester is idle
    for (int n = 0; n < 800; n++) begin
      if (!c_req) begin
        if ($urandom_range(2) == 0) begin
          c_req = 1'b1; c_we = 1'($urandom_range(1));
          c_addr = 16'($urandom); c_wd = 8'($urandom);
        end
      end else if ($urandom_range(5) == 0) c_req = 1'b0;
      if (!l_req) begin
        if ($urandom_range(2) == 0) begin
          l_req = 1'b1; l_we = 1'($urandom_range(1));
          l_addr = 16'($urandom); l_wd = 8'($urandom);
        end
      end else if ($urandom_range(5) == 0) l_req = 1'b0;
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0; c_req = 1'b0; l_req = 1'b0;
    steps(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external 8-bit memory port between two requesters: the CPU bus interface and the front-panel/program loader.
- The CPU port is driven from the datapath's memaddr, data_out, read and write signals.
- The loader port writes or reads program memory from switches while the CPU is halted or stepping.
- Each access is serialised with a req/ack handshake and a fixed-latency memory timing sequence.
- The block sits between the CPU top level and the memory device.

Parameters:
- MEM_LAT, 2, number of cycles mem_read/mem_write are held asserted per access (legal 1..15).
- CPU_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = fixed priority, CPU always wins.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- cpu_req  input  1  CPU access request, level
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  16  CPU address
- cpu_wdata  input  8  CPU write data
- cpu_ack  output  1  one-cycle completion pulse to CPU
- cpu_rdata  output  8  read data, valid while cpu_ack=1
- ld_req  input  1  loader access request, level
- ld_we  input  1  loader write enable
- ld_addr  input  16  loader address
- ld_wdata  input  8  loader write data
- ld_ack  output  1  one-cycle completion pulse to loader
- ld_rdata  output  8  read data, valid while ld_ack=1
- mem_addr  output  16  memory address
- mem_wdata  output  8  memory write data
- mem_rdata  input  8  memory read data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- busy  output  1  1 in every state other than IDLE
- grant_id  output  1  0 = CPU owns port, 1 = loader owns port; meaningful while busy

Behaviour:
- Reset:
  - All outputs are registered; reset drives every output to 0.
  - State returns to IDLE, access counter is cleared, last_grant is set to loader (so the CPU wins the first tie).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples cpu_req and ld_req.
  - Only one request high: grant it.
  - Both high: CPU_PRIO=1 grants CPU; CPU_PRIO=0 grants the requester that is not last_grant.
  - On grant: latch addr, we and wdata of the winner into mem_addr, mem_wdata and an internal we register; set grant_id; go to ACCESS with cnt=0.
  - Neither high: stay in IDLE.
- ACCESS:
  - mem_read = ~we and mem_write = we, held for exactly MEM_LAT consecutive cycles (cnt 0..MEM_LAT-1).
  - mem_addr and mem_wdata stay stable for the whole window.
  - On the edge ending the last ACCESS cycle: capture mem_rdata into the read-data register, drop both strobes, go to DONE.
- DONE:
  - Pulse the granted ack for exactly one cycle.
  - The matching rdata output shows the captured value for reads; for writes rdata is unchanged (don't-care).
  - Update last_grant to the current owner; return to IDLE.
- Latency: if a request is first sampled in IDLE at edge T, strobes are high in cycles T+1..T+MEM_LAT and ack is high in cycle T+MEM_LAT+1.
- Back-to-back rules:
  - A req still high during DONE is not serviced in DONE; it is re-sampled in the following IDLE cycle.
  - Minimum spacing between accesses is MEM_LAT+2 cycles.
- Requester drops req mid-access: the transaction still completes and ack is still pulsed. A requester must not change addr/data while req is high and ack has not yet been seen; the latched copies are used regardless.
- Non-granted requester: its req stays pending, it receives no ack, and it waits until the next IDLE.
- Round-robin fairness (CPU_PRIO=0): with both reqs held high continuously, grants strictly alternate CPU, LD, CPU, LD...
- Fixed priority (CPU_PRIO=1): a continuously requesting CPU starves the loader. This is intended; the loader is only used with the CPU halted.
- mem_read and mem_write are never both 1, and are never 1 outside ACCESS.
- rst asserted mid-ACCESS or mid-DONE:
  - Strobes and ack are 0 from the next cycle; the pending ack is lost.
  - The requester must re-issue after reset.
- grant_id holds its last value in IDLE; busy=0 in IDLE.

Test Plan:
- Single CPU read, MEM_LAT=2: cpu_req=1, cpu_we=0, cpu_addr=0x0010, memory returns 0x5A -> mem_read high exactly 2 cycles with mem_addr=0x0010, cpu_ack high 3 cycles after the sampling edge, cpu_rdata=0x5A, ld_ack stays 0.
- Loader write: ld_req=1, ld_we=1, ld_addr=0x0003, ld_wdata=0xC4 -> mem_write high 2 cycles with mem_wdata=0xC4, grant_id=1, ld_ack one pulse, mem_read never asserted.
- Simultaneous requests held high for 4 accesses, CPU_PRIO=0, just out of reset -> grant order CPU, LD, CPU, LD, each ack exactly one cycle, accesses spaced 4 cycles apart.
- Same stimulus with CPU_PRIO=1 -> 4 CPU grants, ld_ack never asserted; drop cpu_req -> loader granted on the next IDLE.
- CPU drops req one cycle into ACCESS -> strobe window is still MEM_LAT cycles and cpu_ack still pulses once.
- rst pulsed during the 2nd ACCESS cycle of a write -> mem_write=0, busy=0 and no ack on the following cycle; a subsequent tied request grants CPU first.
